// File: rtl/note_player_if.sv
// Note-stream and playback bus between the song reader / codec side and note_player.
// The slave modport is the player's view; master is the driver's view.
interface note_player_if #(
  parameter int PHASE_W = 20,
  parameter int DUR_W   = 6,
  parameter int NOTE_W  = 6
);
  logic               play;
  logic               new_note;
  logic [NOTE_W-1:0]  note;
  logic [DUR_W-1:0]   duration;
  logic               beat;
  logic               generate_next_sample;
  logic [PHASE_W-1:0] step;
  logic [NOTE_W-1:0]  note_out;
  logic [PHASE_W-1:0] phase;
  logic               playing;
  logic               silent;
  logic               note_done;

  modport slave (
    input  play, new_note, note, duration, beat, generate_next_sample, step,
    output note_out, phase, playing, silent, note_done
  );

  modport master (
    output play, new_note, note, duration, beat, generate_next_sample, step,
    input  note_out, phase, playing, silent, note_done
  );
endinterface

// File: rtl/note_player.sv
// Plays one note at a time: latches note/duration, counts beats, steps the phase accumulator.
// Optional NOTE_PLAYER_RELEASE_GAP_EN mutes and holds phase during the last beat of a note.
module note_player #(
  parameter int PHASE_W = 20,
  parameter int DUR_W   = 6,
  parameter int NOTE_W  = 6
) (
  input logic           clk,
  input logic           reset_n,
  note_player_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, PLAYING, DONE} state_t;

  state_t             state, state_nxt;
  logic [NOTE_W-1:0]  note_q;
  logic [DUR_W-1:0]   remaining;
  logic [PHASE_W-1:0] phase_q;
  logic               run, expire, gap, advance;
  logic               playing, silent, note_done;

  assign run     = (state == PLAYING) && bus.play;
  assign expire  = run && bus.beat && (remaining <= DUR_W'(1));
`ifdef NOTE_PLAYER_RELEASE_GAP_EN
  assign gap     = (state == PLAYING) && (remaining == DUR_W'(1));
`else
  assign gap     = 1'b0;
`endif
  assign advance = run && bus.generate_next_sample && (note_q != '0) && !gap;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // A load beats everything, including an expiring beat in the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.new_note) state_nxt = PLAYING;
      PLAYING: if (bus.new_note) state_nxt = PLAYING;
               else if (expire)  state_nxt = DONE;
      DONE:    state_nxt = bus.new_note ? PLAYING : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    playing   = (state == PLAYING);
    note_done = (state == DONE);
    silent    = !playing || !bus.play || (note_q == '0) || gap;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      note_q    <= '0;
      remaining <= '0;
      phase_q   <= '0;
    end else if (bus.new_note) begin
      note_q    <= bus.note;
      remaining <= bus.duration;
      phase_q   <= '0;
    end else begin
      // duration 0 behaves as 1: saturate rather than wrap
      if (run && bus.beat && remaining != '0) remaining <= remaining - DUR_W'(1);
      if (advance) phase_q <= phase_q + bus.step;
    end
  end

  assign bus.note_out  = note_q;
  assign bus.phase     = phase_q;
  assign bus.playing   = playing;
  assign bus.silent    = silent;
  assign bus.note_done = note_done;
endmodule

// File: tb/tb_note_player.sv
// Randomized and directed bench for note_player against a beat/phase reference model.
module tb_note_player;
  localparam int PHASE_W = 20;
  localparam int DUR_W   = 6;
  localparam int NOTE_W  = 6;
  localparam int OW      = NOTE_W + PHASE_W + 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  note_player_if #(.PHASE_W(PHASE_W), .DUR_W(DUR_W), .NOTE_W(NOTE_W)) bus ();
  note_player #(.PHASE_W(PHASE_W), .DUR_W(DUR_W), .NOTE_W(NOTE_W)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave));

  logic [OW-1:0] obs;
  assign obs = {bus.note_out, bus.phase, bus.playing, bus.silent, bus.note_done};

  int vectors = 0;
  int errors  = 0;

  // Reference model: a note is "on" until its beats run out; the done pulse is
  // tagged with the clock number at which it becomes visible.
  bit              m_on;
  int              m_left;
  int              m_note;
  longint unsigned m_ph;
  int              cyc = 0;
  int              done_cyc = -10;

  function automatic void model_reset();
    m_on = 0; m_left = 0; m_note = 0; m_ph = 0; done_cyc = -10;
  endfunction

  function automatic bit m_gap();
`ifdef NOTE_PLAYER_RELEASE_GAP_EN
    return m_on && (m_left == 1);
`else
    return 1'b0;
`endif
  endfunction

  function automatic void model_step();
    if (bus.new_note) begin
      m_on = 1; m_note = int'(bus.note); m_left = int'(bus.duration); m_ph = 0;
    end else if (m_on && bus.play) begin
      if (bus.generate_next_sample && m_note != 0 && !m_gap())
        m_ph = (m_ph + longint'(bus.step)) % (64'd1 << PHASE_W);
      if (bus.beat) begin
        if (m_left <= 1) begin m_on = 0; done_cyc = cyc; end
        else m_left = m_left - 1;
      end
    end
  endfunction

  function automatic logic [OW-1:0] model_outs();
    logic s;
    s = !m_on || !bus.play || (m_note == 0) || m_gap();
    return {NOTE_W'(m_note), PHASE_W'(m_ph), m_on, s, (cyc == done_cyc)};
  endfunction

  task automatic drive(input bit pl, input bit nn, input int nt, input int du,
                       input bit bt, input bit gn, input int st);
    bus.play = pl; bus.new_note = nn; bus.note = NOTE_W'(nt); bus.duration = DUR_W'(du);
    bus.beat = bt; bus.generate_next_sample = gn; bus.step = PHASE_W'(st);
    @(posedge clk);
    cyc++;
    if (!reset_n) model_reset();
    else model_step();
    #1;
  endtask

  task automatic test_reset();
    bus.play = 0; bus.new_note = 0; bus.note = '0; bus.duration = '0;
    bus.beat = 0; bus.generate_next_sample = 0; bus.step = '0;
    reset_n = 0; model_reset();
    #12;
    vectors++;
    if (obs !== {NOTE_W'(0), PHASE_W'(0), 3'b010}) begin
      errors++; $display("FAIL reset_state got=%h exp=%h", obs, {NOTE_W'(0), PHASE_W'(0), 3'b010});
    end
    reset_n = 1;
    drive(1, 1, 9, 5, 0, 1, 'h123);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 1, 1, 'h321);
      vectors++;
      if (obs !== model_outs()) begin
        errors++; $display("FAIL reset_pre cyc=%0d got=%h exp=%h", cyc, obs, model_outs());
      end
    end
    #3 reset_n = 0; model_reset();
    #1;
    vectors++;
    if (obs !== {NOTE_W'(0), PHASE_W'(0), 3'b010}) begin
      errors++; $display("FAIL async_reset got=%h exp=%h", obs, {NOTE_W'(0), PHASE_W'(0), 3'b010});
    end
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 0, 1, 1, 'h321);
      vectors++;
      if (obs !== model_outs() || bus.note_done !== 1'b0) begin
        errors++; $display("FAIL reset_hold cyc=%0d got=%h exp=%h", cyc, obs, model_outs());
      end
    end
    #2 reset_n = 1;
  endtask

  task automatic test_beat_count();
    drive(1, 1, 5, 3, 0, 0, 0);
    for (int b = 1; b <= 3; b++) begin
      for (int i = 0; i < 10; i++) begin
        drive(1, 0, 0, 0, (i == 9), ($urandom % 2) == 1, int'($urandom % (1 << PHASE_W)));
        vectors++;
        if (obs !== model_outs()) begin
          errors++; $display("FAIL beat_count cyc=%0d got=%h exp=%h", cyc, obs, model_outs());
        end
      end
    end
    vectors++;
    if (bus.note_done !== 1'b1 || bus.playing !== 1'b0) begin
      errors++; $display("FAIL beat_count_done done=%b playing=%b exp 1 0", bus.note_done, bus.playing);
    end
    drive(1, 0, 0, 0, 0, 0, 0);
    vectors++;
    if (bus.note_done !== 1'b0 || bus.playing !== 1'b0) begin
      errors++; $display("FAIL beat_count_idle done=%b playing=%b exp 0 0", bus.note_done, bus.playing);
    end
  endtask

  task automatic test_phase();
    drive(1, 1, 5, 40, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(1, 0, 0, 0, 0, 1, 'h01000);
    vectors++;
    if (bus.phase !== 20'h04000 || obs !== model_outs()) begin
      errors++; $display("FAIL phase_accum got=%h exp=%h", bus.phase, 20'h04000);
    end
    drive(1, 1, 5, 40, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 1, 'h00002);
    drive(1, 0, 0, 0, 0, 1, 'hFFFFF);
    vectors++;
    if (bus.phase !== 20'h00001 || obs !== model_outs()) begin
      errors++; $display("FAIL phase_wrap got=%h exp=%h", bus.phase, 20'h00001);
    end
  endtask

  task automatic test_rest();
    drive(1, 1, 0, 2, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 0, 0, (i % 5) == 4, 1, int'($urandom % (1 << PHASE_W)));
      vectors++;
      if (obs !== model_outs() || bus.silent !== 1'b1 || bus.phase !== '0) begin
        errors++; $display("FAIL rest cyc=%0d got=%h exp=%h", cyc, obs, model_outs());
      end
      if (i == 9) begin
        vectors++;
        if (bus.note_done !== 1'b1) begin
          errors++; $display("FAIL rest_done got=%b exp=1", bus.note_done);
        end
      end
    end
  endtask

  task automatic test_pause();
    bit pl;
    int beats;
    beats = 0;
    drive(1, 1, 7, 4, 0, 0, 0);
    // 1 counted beat, 3 paused beats, then 3 more counted beats
    for (int b = 0; b < 7; b++) begin
      pl = !(b >= 1 && b <= 3);
      for (int i = 0; i < 4; i++) begin
        drive(pl, 0, 0, 0, (i == 3), ($urandom % 2) == 1, 'h00400);
        vectors++;
        if (obs !== model_outs()) begin
          errors++; $display("FAIL pause cyc=%0d got=%h exp=%h", cyc, obs, model_outs());
        end
      end
      if (pl) beats++;
      vectors++;
      if (bus.note_done !== (beats == 4)) begin
        errors++; $display("FAIL pause_done beats=%0d got=%b exp=%b", beats, bus.note_done, beats == 4);
      end
    end
  endtask

  task automatic test_back_to_back();
    drive(1, 1, 4, 2, 0, 0, 0);
    drive(1, 0, 0, 0, 1, 1, 'h00010);
    drive(1, 1, 3, 0, 1, 1, 'h00010);
    vectors++;
    if (bus.note_done !== 1'b0 || bus.playing !== 1'b1 || obs !== model_outs()) begin
      errors++; $display("FAIL reload_wins got=%h exp=%h", obs, model_outs());
    end
    drive(1, 0, 0, 0, 0, 1, 'h00010);
    drive(1, 0, 0, 0, 1, 0, 0);
    vectors++;
    if (bus.note_done !== 1'b1 || obs !== model_outs()) begin
      errors++; $display("FAIL dur_zero got=%h exp=%h", obs, model_outs());
    end
    drive(1, 1, 6, 1, 0, 0, 0);
    vectors++;
    if (bus.note_done !== 1'b0 || bus.playing !== 1'b1) begin
      errors++; $display("FAIL done_to_play done=%b playing=%b exp 0 1", bus.note_done, bus.playing);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom % 8) != 0, ($urandom % 24) == 0, int'($urandom % 64) & ((($urandom % 4) == 0) ? 0 : 63),
            int'($urandom % 5), ($urandom % 4) == 0, ($urandom % 3) == 0,
            int'($urandom % (1 << PHASE_W)));
      vectors++;
      if (obs !== model_outs()) begin
        errors++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs, model_outs());
      end
    end
  endtask

  initial begin
    test_reset();
    test_beat_count();
    test_phase();
    test_rest();
    test_pause();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
